// File: rtl/alu_pkg.sv
// alu_pkg: state encoding, default widths and opcodes shared by the loader, its bench and the ALU.
package alu_pkg;
    localparam int DATA_W = 4;
    localparam int OP_W   = 4;
    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        READY   = 2'd3
    } state_t;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1100;
    localparam logic [3:0] OP_NOR = 4'b1110;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, stability counter and one-cycle press pulse.
module button_debouncer #(
    parameter int p_debounceCycles = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CW = $clog2(p_debounceCycles + 1);
    logic s1_q, s2_q, db_q, pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic toggle;
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        toggle = (s2_q != db_q) && (cnt_d == CW'(p_debounceCycles));
    end
    // the pulse is registered alongside the level toggle, so it only fires on 0->1
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= i_btn;
            s2_q    <= s1_q;
            pulse_q <= toggle & ~db_q;
            db_q    <= toggle ? ~db_q : db_q;
            cnt_q   <= (toggle || s2_q == db_q) ? '0 : cnt_d;
        end
    end
    assign o_pulse = pulse_q;
endmodule

// File: rtl/alu_input_loader.sv
// alu_input_loader: debounces three buttons and loads A, B and the opcode from the switches in order.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int p_dataLength     = DATA_W,
    parameter int p_opLength       = OP_W,
    parameter int p_debounceCycles = 1_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [p_dataLength-1:0] i_switches,
    input  logic                    i_btnA,
    input  logic                    i_btnB,
    input  logic                    i_btnOp,
    output logic [p_dataLength-1:0] o_A,
    output logic [p_dataLength-1:0] o_B,
    output logic [p_opLength-1:0]   o_ALUBitsControl,
    output logic                    o_valid
);
    logic pulse_a, pulse_b, pulse_op;
    logic [p_dataLength-1:0] sw1_q, sw2_q, a_q, b_q;
    logic [p_opLength-1:0] op_q;
    logic valid_q;
    state_t state_q;

    button_debouncer #(.p_debounceCycles(p_debounceCycles)) u_db_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btnA), .o_pulse(pulse_a));
    button_debouncer #(.p_debounceCycles(p_debounceCycles)) u_db_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btnB), .o_pulse(pulse_b));
    button_debouncer #(.p_debounceCycles(p_debounceCycles)) u_db_op (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btnOp), .o_pulse(pulse_op));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sw1_q <= '0;
            sw2_q <= '0;
        end else begin
            sw1_q <= i_switches;
            sw2_q <= sw1_q;
        end
    end

    // only the expected button acts while waiting; in READY A wins over B over Op
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (pulse_a) begin
                    a_q     <= sw2_q;
                    state_q <= WAIT_B;
                end
                WAIT_B: if (pulse_b) begin
                    b_q     <= sw2_q;
                    state_q <= WAIT_OP;
                end
                WAIT_OP: if (pulse_op) begin
                    op_q    <= sw2_q[p_opLength-1:0];
                    state_q <= READY;
                    valid_q <= 1'b1;
                end
                default: if (pulse_a) begin
                    a_q     <= sw2_q;
                    state_q <= WAIT_B;
                    valid_q <= 1'b0;
                end else if (pulse_b) begin
                    b_q <= sw2_q;
                end else if (pulse_op) begin
                    op_q <= sw2_q[p_opLength-1:0];
                end
            endcase
        end
    end

    assign o_A              = a_q;
    assign o_B              = b_q;
    assign o_ALUBitsControl = op_q;
    assign o_valid          = valid_q;
endmodule
